// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: stage/butterfly address sequencer for an in-place radix-2 DIT FFT
module fft_stage_sequencer #(
  parameter int LOG2N = 3,
  parameter int LAT = 3,
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [SW-1:0]    stage
);
  localparam int JW = LOG2N - 1;
  localparam int TW = LOG2N - 1;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [JW-1:0] JMAX = JW'((1 << JW) - 1);
  localparam logic [DW-1:0] DMAX = DW'(LAT - 1);
  localparam logic [SW-1:0] SMAX = SW'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [SW-1:0]    s_q, s_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [LOG2N-1:0] ra_q, ra_d, rb_q, rb_d, jx, mk;
  logic [TW-1:0]    tw_q, tw_d;
  logic             wv_q [LAT];
  logic             wv_d [LAT];
  logic [LOG2N-1:0] wa_q [LAT];
  logic [LOG2N-1:0] wa_d [LAT];
  logic [LOG2N-1:0] wb_q [LAT];
  logic [LOG2N-1:0] wb_d [LAT];

  // FSM next state: issue N/2 butterflies, drain LAT cycles, repeat per stage, then pulse done
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:
        if (start) begin
          state_d = ISSUE;
          j_d     = '0;
          s_d     = '0;
          rd_en_d = 1'b1;
        end
      ISSUE:
        if (j_q == JMAX) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          j_d     = j_q + 1'b1;
          rd_en_d = 1'b1;
        end
      DRAIN:
        if (cnt_q != DMAX) cnt_d = cnt_q + 1'b1;
        else if (s_q == SMAX) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = ISSUE;
          s_d     = s_q + 1'b1;
          j_d     = '0;
          rd_en_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    if (sclr) begin
      state_d = IDLE;
      j_d     = '0;
      s_d     = '0;
      cnt_d   = '0;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
  end

  // Butterfly addresses for the next issued j, plus the write-back delay line
  always_comb begin
    jx   = {1'b0, j_d};
    mk   = (LOG2N'(1) << s_d) - LOG2N'(1);
    ra_d = sclr ? '0 : ((((jx >> s_d) << s_d) << 1) | (jx & mk));
    rb_d = sclr ? '0 : ra_d + (LOG2N'(1) << s_d);
    tw_d = sclr ? '0 : TW'((jx & mk) << (TW - int'(s_d)));
    wv_d[0] = sclr ? 1'b0 : rd_en_q;
    wa_d[0] = sclr ? '0 : ra_q;
    wb_d[0] = sclr ? '0 : rb_q;
    for (int i = 1; i < LAT; i++) begin
      wv_d[i] = sclr ? 1'b0 : wv_q[i-1];
      wa_d[i] = sclr ? '0 : wa_q[i-1];
      wb_d[i] = sclr ? '0 : wb_q[i-1];
    end
  end

  // State, counters, registered outputs and delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      tw_q    <= '0;
      for (int i = 0; i < LAT; i++) begin
        wv_q[i] <= 1'b0;
        wa_q[i] <= '0;
        wb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      tw_q    <= tw_d;
      for (int i = 0; i < LAT; i++) begin
        wv_q[i] <= wv_d[i];
        wa_q[i] <= wa_d[i];
        wb_q[i] <= wb_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = ra_q;
  assign rd_addr_b = rb_q;
  assign tw_addr   = tw_q;
  assign wr_en     = wv_q[LAT-1];
  assign wr_addr_a = wa_q[LAT-1];
  assign wr_addr_b = wb_q[LAT-1];
  assign stage     = s_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of FFT sequencer timing, addresses, sclr and reset
module tb_fft_stage_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, sclr = 1'b0, start = 1'b0, start2 = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_a, rd_b, wr_a, wr_b;
  logic [1:0] tw, stg;
  logic       busy2, done2, rd_en2, wr_en2;
  logic [3:0] rd_a2, rd_b2, wr_a2, wr_b2;
  logic [2:0] tw2;
  logic [1:0] stg2;
  int errors = 0, checks = 0;
  int ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int et [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_stage_sequencer #(.LOG2N(3), .LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .tw_addr(tw), .wr_en(wr_en),
    .wr_addr_a(wr_a), .wr_addr_b(wr_b), .stage(stg)
  );

  fft_stage_sequencer #(.LOG2N(4), .LAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr_a(rd_a2), .rd_addr_b(rd_b2), .tw_addr(tw2), .wr_en(wr_en2),
    .wr_addr_a(wr_a2), .wr_addr_b(wr_b2), .stage(stg2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input string tag);
    chk({tag, ".rd_en"}, int'(rd_en), 0);
    chk({tag, ".wr_en"}, int'(wr_en), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".rd_a"}, int'(rd_a), 0);
    chk({tag, ".rd_b"}, int'(rd_b), 0);
    chk({tag, ".tw"}, int'(tw), 0);
    chk({tag, ".wr_a"}, int'(wr_a), 0);
    chk({tag, ".stage"}, int'(stg), 0);
  endtask

  // Caller has just had start sampled; we sit in cycle 1 and walk to the done cycle 22
  task automatic nominal(input string tag, input bit pulse);
    int k = 0, w = 0;
    bit er, ew;
    for (int c = 1; c <= 22; c++) begin
      er = (c >= 1 && c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18);
      ew = (c >= 4 && c <= 7) || (c >= 11 && c <= 14) || (c >= 18 && c <= 21);
      chk($sformatf("%s.c%0d.rd_en", tag, c), int'(rd_en), int'(er));
      chk($sformatf("%s.c%0d.wr_en", tag, c), int'(wr_en), int'(ew));
      chk($sformatf("%s.c%0d.busy", tag, c), int'(busy), int'(c <= 21));
      chk($sformatf("%s.c%0d.done", tag, c), int'(done), int'(c == 22));
      if (c <= 21) chk($sformatf("%s.c%0d.stage", tag, c), int'(stg), (c - 1) / 7);
      if (er && k < 12) begin
        chk($sformatf("%s.c%0d.rd_a", tag, c), int'(rd_a), ea[k]);
        chk($sformatf("%s.c%0d.rd_b", tag, c), int'(rd_b), eb[k]);
        chk($sformatf("%s.c%0d.tw", tag, c), int'(tw), et[k]);
        k++;
      end
      if (ew && w < 12) begin
        chk($sformatf("%s.c%0d.wr_a", tag, c), int'(wr_a), ea[w]);
        chk($sformatf("%s.c%0d.wr_b", tag, c), int'(wr_b), eb[w]);
        w++;
      end
      start = pulse && (c == 5 || c == 22);
      if (c < 22) step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, last, nrd, dcyc;
    step();
    zeros("reset");
    chk("reset.busy2", int'(busy2), 0);
    chk("reset.wr_en2", int'(wr_en2), 0);
    rst_n = 1'b1;
    step();
    step();
    // nominal transform
    start = 1'b1;
    step();
    start = 1'b0;
    nominal("nom", 1'b0);
    step();
    chk("nom.after.busy", int'(busy), 0);
    chk("nom.after.done", int'(done), 0);
    // starts at 5 and 22 ignored, start at 23 launches
    start = 1'b1;
    step();
    start = 1'b0;
    nominal("ign", 1'b1);
    step();
    chk("ign.c23.done", int'(done), 0);
    chk("ign.c23.rd_en", int'(rd_en), 0);
    chk("ign.c23.busy", int'(busy), 0);
    step();
    start = 1'b0;
    chk("ign.c24.rd_en", int'(rd_en), 1);
    chk("ign.c24.rd_a", int'(rd_a), 0);
    chk("ign.c24.rd_b", int'(rd_b), 1);
    chk("ign.c24.busy", int'(busy), 1);
    // sclr at relative cycle 10 of the new transform
    for (int r = 2; r <= 10; r++) begin
      step();
      chk($sformatf("sclr.r%0d.done", r), int'(done), 0);
    end
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    for (int r = 11; r <= 13; r++) begin
      chk($sformatf("sclr.r%0d.rd_en", r), int'(rd_en), 0);
      chk($sformatf("sclr.r%0d.wr_en", r), int'(wr_en), 0);
      chk($sformatf("sclr.r%0d.busy", r), int'(busy), 0);
      chk($sformatf("sclr.r%0d.done", r), int'(done), 0);
      start = (r == 13);
      step();
    end
    start = 1'b0;
    nominal("restart", 1'b0);
    // asynchronous reset at cycle 16 of a fresh transform
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    chk("rst.c16.pre_rd_en", int'(rd_en), 1);
    rst_n = 1'b0;
    #1;
    zeros("rst.async");
    chk("rst.async.rd_b", int'(rd_b), 0);
    step();
    step();
    zeros("rst.held");
    rst_n = 1'b1;
    for (int r = 0; r < 30; r++) begin
      step();
      chk($sformatf("rst.idle%0d.done", r), int'(done), 0);
      chk($sformatf("rst.idle%0d.busy", r), int'(busy), 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    nominal("postrst", 1'b0);
    // LOG2N=4, LAT=1 sweep
    step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    first = -1;
    last = -1;
    nrd = 0;
    dcyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 9) chk("swp.c9.rd_en", int'(rd_en2), 0);
      if (c == 10) chk("swp.c10.rd_en", int'(rd_en2), 1);
      if (rd_en2) begin
        if (first < 0) first = c;
        chk($sformatf("swp.c%0d.stage", c), int'(stg2), nrd / 8);
        if (nrd / 8 == 0) chk($sformatf("swp.c%0d.tw0", c), int'(tw2), 0);
        if (nrd / 8 == 3) chk($sformatf("swp.c%0d.tw3", c), int'(tw2), nrd % 8);
        nrd++;
      end
      if (wr_en2) last = c;
      if (done2 && dcyc < 0) dcyc = c;
      step();
    end
    chk("swp.first_rd", first, 1);
    chk("swp.last_wr", last, 36);
    chk("swp.span", last - first + 1, 36);
    chk("swp.nrd", nrd, 32);
    chk("swp.done_cycle", dcyc, 37);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
